// File: rtl/it_state_ctrl.sv
// it_state_ctrl: Thumb-2 If-Then (IT) block sequencer.
//
// Holds ITSTATE. An IT instruction loads it, and each instruction that retires
// inside the block advances it. The block also provides the condition code for
// the current instruction and tests it against the APSR flags.
//
// Ports:
//   clk, rst        - clock and asynchronous active-high reset
//   it_load         - IT instruction issued; it_firstcond / it_mask are its fields
//   instr_retire    - one instruction retires; advances ITSTATE inside a block
//   flush           - redirect; abandons the current IT block
//   itstate_wr      - restore ITSTATE from itstate_wdata (exception return)
//   apsr_nzcv       - flags {N,Z,C,V}
//   itstate         - current ITSTATE (stacked on exception entry)
//   in_it_block     - ITSTATE[3:0] != 0
//   last_in_it      - current instruction is the last one in the block
//   cur_cond        - condition for the current instruction (AL_COND outside a block)
//   cond_passed     - cur_cond evaluated against apsr_nzcv
//   it_remaining    - instructions left in the block, including the current one
//   it_err          - one-cycle registered pulse on an unpredictable IT encoding
module it_state_ctrl #(
    parameter logic [3:0] AL_COND = 4'b1110
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       it_load,
    input  logic [3:0] it_firstcond,
    input  logic [3:0] it_mask,
    input  logic       instr_retire,
    input  logic       flush,
    input  logic       itstate_wr,
    input  logic [7:0] itstate_wdata,
    input  logic [3:0] apsr_nzcv,
    output logic [7:0] itstate,
    output logic       in_it_block,
    output logic       last_in_it,
    output logic [3:0] cur_cond,
    output logic       cond_passed,
    output logic [2:0] it_remaining,
    output logic       it_err
);

    logic [7:0] itstate_q, itstate_d;
    logic       it_err_q, it_err_d;
    logic       in_blk;
    logic       load_bad;
    logic       base_pass;
    logic       flag_n, flag_z, flag_c, flag_v;

    assign in_blk = (itstate_q[3:0] != 4'b0000);

    // Unpredictable IT encodings. These are evaluated only when it_mask is
    // nonzero, because a zero mask is a hint and not an IT instruction.
    assign load_bad = in_blk
                   || (it_firstcond == 4'b1111)
                   || ((it_firstcond == 4'b1110) && (it_mask != 4'b1000));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            itstate_q <= '0;
            it_err_q  <= 1'b0;
        end else begin
            itstate_q <= itstate_d;
            it_err_q  <= it_err_d;
        end
    end

    always_comb begin
        itstate_d = itstate_q;
        it_err_d  = 1'b0;
        if (flush) begin
            itstate_d = '0;
        end else if (itstate_wr) begin
            itstate_d = itstate_wdata;
        end else if (it_load) begin
            // A concurrent retire is the IT instruction itself, so it never
            // advances the state here. A zero mask leaves everything as it was.
            if (it_mask != 4'b0000) begin
                if (load_bad) begin
                    itstate_d = '0;
                    it_err_d  = 1'b1;
                end else begin
                    itstate_d = {it_firstcond, it_mask};
                end
            end
        end else if (instr_retire && in_blk) begin
            if (itstate_q[2:0] == 3'b000) begin
                itstate_d = '0;
            end else begin
                // Shift ITSTATE[4:0] left by one while the base condition [7:5] holds
                itstate_d = {itstate_q[7:5], itstate_q[3:0], 1'b0};
            end
        end
    end

    assign {flag_n, flag_z, flag_c, flag_v} = apsr_nzcv;

    always_comb begin
        itstate      = itstate_q;
        it_err       = it_err_q;
        in_it_block  = in_blk;
        last_in_it   = (itstate_q[3:0] == 4'b1000);
        cur_cond     = in_blk ? itstate_q[7:4] : AL_COND;

        // The position of the lowest set mask bit gives the number of instructions left
        if (itstate_q[0])      it_remaining = 3'd4;
        else if (itstate_q[1]) it_remaining = 3'd3;
        else if (itstate_q[2]) it_remaining = 3'd2;
        else if (itstate_q[3]) it_remaining = 3'd1;
        else                   it_remaining = 3'd0;

        case (cur_cond[3:1])
            3'b000:  base_pass = flag_z;
            3'b001:  base_pass = flag_c;
            3'b010:  base_pass = flag_n;
            3'b011:  base_pass = flag_v;
            3'b100:  base_pass = flag_c & ~flag_z;
            3'b101:  base_pass = (flag_n == flag_v);
            3'b110:  base_pass = (flag_n == flag_v) & ~flag_z;
            default: base_pass = 1'b1;
        endcase

        // 4'b1111 behaves as always-true and is not inverted
        if (cur_cond[0] && (cur_cond != 4'b1111))
            cond_passed = ~base_pass;
        else
            cond_passed = base_pass;
    end

endmodule

// File: tb/tb_it_state_ctrl.sv
module tb_it_state_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       it_load = 1'b0;
    logic [3:0] it_firstcond = '0;
    logic [3:0] it_mask = '0;
    logic       instr_retire = 1'b0;
    logic       flush = 1'b0;
    logic       itstate_wr = 1'b0;
    logic [7:0] itstate_wdata = '0;
    logic [3:0] apsr_nzcv = '0;
    logic [7:0] itstate;
    logic       in_it_block;
    logic       last_in_it;
    logic [3:0] cur_cond;
    logic       cond_passed;
    logic [2:0] it_remaining;
    logic       it_err;

    int n_checks = 0;
    int n_fail   = 0;

    it_state_ctrl #(.AL_COND(4'b1110)) dut (
        .clk(clk), .rst(rst),
        .it_load(it_load), .it_firstcond(it_firstcond), .it_mask(it_mask),
        .instr_retire(instr_retire), .flush(flush),
        .itstate_wr(itstate_wr), .itstate_wdata(itstate_wdata),
        .apsr_nzcv(apsr_nzcv),
        .itstate(itstate), .in_it_block(in_it_block), .last_in_it(last_in_it),
        .cur_cond(cur_cond), .cond_passed(cond_passed),
        .it_remaining(it_remaining), .it_err(it_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic [3:0] fc;
        logic [3:0] mk;
        logic       ret;
        logic       fl;
        logic       wr;
        logic [7:0] wd;
        logic [3:0] nzcv;
        logic [7:0] e_its;
        logic [3:0] e_cond;
        logic       e_pass;
        logic [2:0] e_rem;
        logic       e_last;
        logic       e_inb;
        logic       e_err;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        it_load = 1'b0; it_firstcond = '0; it_mask = '0;
        instr_retire = 1'b0; flush = 1'b0; itstate_wr = 1'b0; itstate_wdata = '0;
    endtask

    // Architectural condition table, written per mnemonic
    function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    logic [3:0] pats[5];

    initial begin
        //           ld   fc    mk    ret  fl   wr   wd     nzcv     its    cond  pass rem   last inb  err
        // ITTE EQ with Z=1
        vecs[0]  = '{1'b1,4'h0,4'h6,1'b1,1'b0,1'b0,8'h00,4'b0100, 8'h06,4'h0,1'b1,3'd3,1'b0,1'b1,1'b0};
        vecs[1]  = '{1'b0,4'h0,4'h0,1'b1,1'b0,1'b0,8'h00,4'b0100, 8'h0C,4'h0,1'b1,3'd2,1'b0,1'b1,1'b0};
        vecs[2]  = '{1'b0,4'h0,4'h0,1'b1,1'b0,1'b0,8'h00,4'b0100, 8'h18,4'h1,1'b0,3'd1,1'b1,1'b1,1'b0};
        vecs[3]  = '{1'b0,4'h0,4'h0,1'b1,1'b0,1'b0,8'h00,4'b0100, 8'h00,4'hE,1'b1,3'd0,1'b0,1'b0,1'b0};
        // ITT GT, then stall for five cycles
        vecs[4]  = '{1'b1,4'hC,4'h4,1'b0,1'b0,1'b0,8'h00,4'b0000, 8'hC4,4'hC,1'b1,3'd2,1'b0,1'b1,1'b0};
        vecs[5]  = '{1'b0,4'h0,4'h0,1'b0,1'b0,1'b0,8'h00,4'b0000, 8'hC4,4'hC,1'b1,3'd2,1'b0,1'b1,1'b0};
        vecs[6]  = vecs[5];
        vecs[7]  = vecs[5];
        vecs[8]  = vecs[5];
        vecs[9]  = vecs[5];
        vecs[10] = '{1'b0,4'h0,4'h0,1'b1,1'b0,1'b0,8'h00,4'b0000, 8'hC8,4'hC,1'b1,3'd1,1'b1,1'b1,1'b0};
        vecs[11] = '{1'b0,4'h0,4'h0,1'b1,1'b0,1'b0,8'h00,4'b0000, 8'h00,4'hE,1'b1,3'd0,1'b0,1'b0,1'b0};
        // Four-instruction block, one retire, then flush together with retire
        vecs[12] = '{1'b1,4'h1,4'h1,1'b0,1'b0,1'b0,8'h00,4'b0000, 8'h11,4'h1,1'b1,3'd4,1'b0,1'b1,1'b0};
        vecs[13] = '{1'b0,4'h0,4'h0,1'b1,1'b0,1'b0,8'h00,4'b0000, 8'h02,4'h0,1'b0,3'd3,1'b0,1'b1,1'b0};
        vecs[14] = '{1'b0,4'h0,4'h0,1'b1,1'b1,1'b0,8'h00,4'b0000, 8'h00,4'hE,1'b1,3'd0,1'b0,1'b0,1'b0};
        // firstcond = F is an error, and the pulse lasts one cycle
        vecs[15] = '{1'b1,4'hF,4'h8,1'b0,1'b0,1'b0,8'h00,4'b0000, 8'h00,4'hE,1'b1,3'd0,1'b0,1'b0,1'b1};
        vecs[16] = '{1'b0,4'h0,4'h0,1'b0,1'b0,1'b0,8'h00,4'b0000, 8'h00,4'hE,1'b1,3'd0,1'b0,1'b0,1'b0};
        // IT issued inside an IT block
        vecs[17] = '{1'b1,4'h0,4'h8,1'b0,1'b0,1'b0,8'h00,4'b0100, 8'h08,4'h0,1'b1,3'd1,1'b1,1'b1,1'b0};
        vecs[18] = '{1'b1,4'h2,4'h8,1'b0,1'b0,1'b0,8'h00,4'b0100, 8'h00,4'hE,1'b1,3'd0,1'b0,1'b0,1'b1};
        vecs[19] = '{1'b0,4'h0,4'h0,1'b0,1'b0,1'b0,8'h00,4'b0100, 8'h00,4'hE,1'b1,3'd0,1'b0,1'b0,1'b0};
        // AL firstcond: only mask 1000 is legal
        vecs[20] = '{1'b1,4'hE,4'h4,1'b0,1'b0,1'b0,8'h00,4'b0000, 8'h00,4'hE,1'b1,3'd0,1'b0,1'b0,1'b1};
        vecs[21] = '{1'b1,4'hE,4'h8,1'b0,1'b0,1'b0,8'h00,4'b0000, 8'hE8,4'hE,1'b1,3'd1,1'b1,1'b1,1'b0};
        vecs[22] = '{1'b0,4'h0,4'h0,1'b1,1'b0,1'b0,8'h00,4'b0000, 8'h00,4'hE,1'b1,3'd0,1'b0,1'b0,1'b0};
        // Zero mask is a hint: no change and no error
        vecs[23] = '{1'b1,4'h3,4'h0,1'b0,1'b0,1'b0,8'h00,4'b0000, 8'h00,4'hE,1'b1,3'd0,1'b0,1'b0,1'b0};
        // Restore 8'h18, then retire
        vecs[24] = '{1'b0,4'h0,4'h0,1'b0,1'b0,1'b1,8'h18,4'b0000, 8'h18,4'h1,1'b1,3'd1,1'b1,1'b1,1'b0};
        vecs[25] = '{1'b0,4'h0,4'h0,1'b1,1'b0,1'b0,8'h00,4'b0000, 8'h00,4'hE,1'b1,3'd0,1'b0,1'b0,1'b0};
        // Priority: itstate_wr over it_load, and flush over everything
        vecs[26] = '{1'b1,4'h0,4'h8,1'b0,1'b0,1'b1,8'h34,4'b0000, 8'h34,4'h3,1'b1,3'd2,1'b0,1'b1,1'b0};
        vecs[27] = '{1'b1,4'h0,4'h8,1'b1,1'b1,1'b1,8'h18,4'b0000, 8'h00,4'hE,1'b1,3'd0,1'b0,1'b0,1'b0};

        pats[0] = 4'b0000; pats[1] = 4'b0110; pats[2] = 4'b1001;
        pats[3] = 4'b1111; pats[4] = 4'b1010;

        // Check reset values while reset is asserted
        apsr_nzcv = 4'b0100;
        #1;
        chk("rst itstate", itstate, 8'h00);
        chk("rst cur_cond", {4'h0, cur_cond}, 8'h0E);
        chk("rst cond_passed", {7'h0, cond_passed}, 8'h01);
        chk("rst it_err", {7'h0, it_err}, 8'h00);
        chk("rst in_it_block", {7'h0, in_it_block}, 8'h00);
        chk("rst last_in_it", {7'h0, last_in_it}, 8'h00);
        chk("rst it_remaining", {5'h0, it_remaining}, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            it_load = vecs[i].ld; it_firstcond = vecs[i].fc; it_mask = vecs[i].mk;
            instr_retire = vecs[i].ret; flush = vecs[i].fl;
            itstate_wr = vecs[i].wr; itstate_wdata = vecs[i].wd;
            apsr_nzcv = vecs[i].nzcv;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d itstate", i), itstate, vecs[i].e_its);
            chk($sformatf("v%0d cur_cond", i), {4'h0, cur_cond}, {4'h0, vecs[i].e_cond});
            chk($sformatf("v%0d cond_passed", i), {7'h0, cond_passed}, {7'h0, vecs[i].e_pass});
            chk($sformatf("v%0d it_remaining", i), {5'h0, it_remaining}, {5'h0, vecs[i].e_rem});
            chk($sformatf("v%0d last_in_it", i), {7'h0, last_in_it}, {7'h0, vecs[i].e_last});
            chk($sformatf("v%0d in_it_block", i), {7'h0, in_it_block}, {7'h0, vecs[i].e_inb});
            chk($sformatf("v%0d it_err", i), {7'h0, it_err}, {7'h0, vecs[i].e_err});
        end

        // Asynchronous reset in the middle of a block clears the block with no clock edge
        @(negedge clk);
        drive_idle();
        it_load = 1'b1; it_firstcond = 4'h5; it_mask = 4'h2;
        @(posedge clk);
        #1;
        chk("async pre itstate", itstate, 8'h52);
        @(negedge clk);
        drive_idle();
        #1;
        rst = 1'b1;
        #1;
        chk("async itstate", itstate, 8'h00);
        chk("async in_it_block", {7'h0, in_it_block}, 8'h00);
        chk("async cur_cond", {4'h0, cur_cond}, 8'h0E);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset also clears a pending error pulse
        @(negedge clk);
        it_load = 1'b1; it_firstcond = 4'hF; it_mask = 4'h8;
        @(posedge clk);
        #1;
        chk("async err set", {7'h0, it_err}, 8'h01);
        #1;
        rst = 1'b1;
        #1;
        chk("async err clr", {7'h0, it_err}, 8'h00);
        @(negedge clk);
        drive_idle();
        rst = 1'b0;

        // Sweep all condition codes against several flag patterns
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            drive_idle();
            itstate_wr = 1'b1;
            itstate_wdata = {c[3:0], 4'b1000};
            @(posedge clk);
            #1;
            itstate_wr = 1'b0;
            chk($sformatf("sweep cur_cond %0d", c), {4'h0, cur_cond}, {4'h0, c[3:0]});
            for (int k = 0; k < 5; k++) begin
                apsr_nzcv = pats[k];
                #1;
                chk($sformatf("sweep cond %0d nzcv %b", c, pats[k]),
                    {7'h0, cond_passed}, {7'h0, cond_model(c[3:0], pats[k])});
            end
        end
        @(negedge clk);
        drive_idle();
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk("final flush itstate", itstate, 8'h00);
        @(negedge clk);
        drive_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
